// File: rtl/multicycle_alu.sv
// Handshaked ALU: single-cycle logic/shift/add ops, iterative W-cycle MULT and restoring DIV.
// Define MULTICYCLE_ALU_FAST_MUL_EN to replace the iterative MULT with a one-cycle multiplier.
module multicycle_alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               zero,
    output logic               sign,
    output logic               overflow,
    output logic               carry,
    output logic               div0,
    output logic               busy
);

    localparam int unsigned CntW = $clog2(WIDTH);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [3:0] OpOr   = 4'd0;
    localparam logic [3:0] OpAnd  = 4'd1;
    localparam logic [3:0] OpMult = 4'd2;
    localparam logic [3:0] OpRol  = 4'd3;
    localparam logic [3:0] OpRor  = 4'd4;
    localparam logic [3:0] OpShl  = 4'd5;
    localparam logic [3:0] OpShr  = 4'd6;
    localparam logic [3:0] OpSub  = 4'd7;
    localparam logic [3:0] OpAdd  = 4'd8;
    localparam logic [3:0] OpDiv  = 4'd9;

    logic [1:0]         state_q, state_d;
    logic [CntW-1:0]    cnt_q;
    logic               is_mul_q;
    logic [WIDTH-1:0]   hi_q, lo_q, opnd_q;
    logic [2*WIDTH-1:0] result_q;
    logic               zero_q, sign_q, overflow_q, carry_q, div0_q;

    logic               accept, long_op, load;
    logic [WIDTH:0]     add_w, sub_w;
    int unsigned        rot_amt;
    logic               big_shift;
    logic [WIDTH-1:0]   sc_lo, sc_hi;
    logic               sc_carry, sc_ovf, sc_div0;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] fin_res;
    logic               fin_carry, fin_ovf, fin_div0, fin_mul;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StBusy);
    assign accept    = in_valid && in_ready;

`ifdef MULTICYCLE_ALU_FAST_MUL_EN
    assign long_op = (op == OpDiv) && (b != '0);
`else
    assign long_op = ((op == OpDiv) && (b != '0)) || (op == OpMult);
`endif

    // Single-cycle datapath, evaluated on the live inputs at the accept edge.
    always_comb begin
        sc_lo     = '0;
        sc_hi     = '0;
        sc_carry  = 1'b0;
        sc_ovf    = 1'b0;
        sc_div0   = 1'b0;
        add_w     = {1'b0, a} + {1'b0, b};
        sub_w     = {1'b0, a} - {1'b0, b};
        rot_amt   = 32'(b) % WIDTH;
        big_shift = 32'(b) >= WIDTH;
        case (op)
            OpOr:  sc_lo = a | b;
            OpAnd: sc_lo = a & b;
`ifdef MULTICYCLE_ALU_FAST_MUL_EN
            OpMult: {sc_hi, sc_lo} = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif
            OpRol: sc_lo = (a << rot_amt) | (a >> (WIDTH - rot_amt));
            OpRor: sc_lo = (a >> rot_amt) | (a << (WIDTH - rot_amt));
            OpShl: sc_lo = big_shift ? '0 : (a << b);
            OpShr: sc_lo = big_shift ? '0 : (a >> b);
            OpSub: begin
                sc_lo    = sub_w[WIDTH-1:0];
                sc_carry = sub_w[WIDTH];
                sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OpAdd: begin
                sc_lo    = add_w[WIDTH-1:0];
                sc_carry = add_w[WIDTH];
                sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OpDiv: sc_div0 = 1'b1;
            default: sc_lo = '0;
        endcase
    end

    // One iteration step. MULT: {hi,lo} = {partial, multiplier}, shifted right.
    // DIV: {hi,lo} = {remainder, dividend/quotient}, shifted left. Both end as {upper, lower}.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, opnd_q};
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        step_hi   = hi_q;
        step_lo   = lo_q;
        if (is_mul_q) begin
            if (lo_q[0]) begin
                {step_hi, step_lo} = {mul_sum, lo_q[WIDTH-1:1]};
            end else begin
                {step_hi, step_lo} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
            end
        end else if (!div_diff[WIDTH]) begin
            step_hi = div_diff[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            step_hi = div_shift[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept) state_d = long_op ? StBusy : StDone;
            StBusy: if (cnt_q == '0) state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fin_res   = {sc_hi, sc_lo};
        fin_carry = sc_carry;
        fin_ovf   = sc_ovf;
        fin_div0  = sc_div0;
        fin_mul   = (op == OpMult);
        if (state_q == StBusy) begin
            fin_res   = {step_hi, step_lo};
            fin_carry = 1'b0;
            fin_ovf   = 1'b0;
            fin_div0  = 1'b0;
            fin_mul   = is_mul_q;
        end
    end

    assign load = (accept && !long_op) || ((state_q == StBusy) && (cnt_q == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            is_mul_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
        end else if (accept && long_op) begin
            cnt_q    <= CntW'(WIDTH - 1);
            is_mul_q <= (op == OpMult);
            hi_q     <= '0;
            lo_q     <= (op == OpMult) ? b : a;
            opnd_q   <= (op == OpMult) ? a : b;
        end else if (state_q == StBusy) begin
            cnt_q <= cnt_q - 1'b1;
            hi_q  <= step_hi;
            lo_q  <= step_lo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= '0;
            zero_q     <= 1'b0;
            sign_q     <= 1'b0;
            overflow_q <= 1'b0;
            carry_q    <= 1'b0;
            div0_q     <= 1'b0;
        end else if (load) begin
            result_q   <= fin_res;
            zero_q     <= (fin_res == '0);
            sign_q     <= fin_mul ? fin_res[2*WIDTH-1] : fin_res[WIDTH-1];
            overflow_q <= fin_ovf;
            carry_q    <= fin_carry;
            div0_q     <= fin_div0;
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign sign     = sign_q;
    assign overflow = overflow_q;
    assign carry    = carry_q;
    assign div0     = div0_q;

endmodule
